// File: rtl/audio_mem_pkg.sv
// Shared definitions for the audio memory port arbiter.
//  - DEF_ADDR_W / DEF_DATA_W : default word address width and sample width
//  - REQ_* : requester indices (record, play, mix, pitch)
//  - arb_state_t : arbiter FSM state encoding
package audio_mem_pkg;

    localparam int DEF_ADDR_W = 23;
    localparam int DEF_DATA_W = 16;

    localparam int REQ_REC   = 0;
    localparam int REQ_PLAY  = 1;
    localparam int REQ_MIX   = 2;
    localparam int REQ_PITCH = 3;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_RD
    } arb_state_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the audio engines, the arbiter and the memory controller.
// Ports / signals:
//  i_req, i_we, i_addr, i_wdata : per-requester request fields (flattened, slice k = requester k)
//  o_gnt, o_ack, o_rdata        : per-requester grant/ack pulses and read data
//  o_mem_*                      : request towards the memory controller
//  i_mem_ready, i_mem_rvalid,
//  i_mem_rdata                  : responses from the memory controller
//  o_busy                       : arbiter not idle
// Modports: slave = arbiter side, master = engines/memory (driver) side.
interface sram_port_arbiter_if
    import audio_mem_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
);
    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ-1:0]        i_we;
    logic [NUM_REQ*ADDR_W-1:0] i_addr;
    logic [NUM_REQ*DATA_W-1:0] i_wdata;
    logic [NUM_REQ-1:0]        o_gnt;
    logic [NUM_REQ-1:0]        o_ack;
    logic [DATA_W-1:0]         o_rdata;
    logic                      o_mem_req;
    logic                      o_mem_we;
    logic [ADDR_W-1:0]         o_mem_addr;
    logic [DATA_W-1:0]         o_mem_wdata;
    logic                      i_mem_ready;
    logic                      i_mem_rvalid;
    logic [DATA_W-1:0]         i_mem_rdata;
    logic                      o_busy;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_gnt, o_ack, o_rdata, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_gnt, o_ack, o_rdata, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
// Ports:
//  req   : request vector (N bits)
//  ptr   : index where the search starts; the search wraps from N-1 to 0
//  gnt   : one-hot winner (all zero when nothing requests)
//  found : high when any request was found
module rr_picker #(
    parameter  int N     = 3,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             found
);

    int unsigned idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[PTR_W'(idx)]) begin
                gnt[PTR_W'(idx)] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the single audio memory port among record (0), play (1), mix (2)
// and pitch (3). Record has fixed priority; the others are round-robin.
// One transaction outstanding at a time.
// Ports:
//  i_clk, i_rst : clock, asynchronous active-high reset
//  bus          : sram_port_arbiter_if.slave (requesters, memory port, o_busy)
// Optional feature macro: ARB_STARVE_GUARD_EN -- per-requester wait counters
// let a requester 1..NUM_REQ-1 waiting >= STARVE_LIMIT cycles win ahead of
// record. Undefined: strict record priority, no counters.
module sram_port_arbiter
    import audio_mem_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    sram_port_arbiter_if.slave bus
);

    localparam int IDX_W    = $clog2(NUM_REQ);
    localparam int RR_N     = NUM_REQ - 1;
    localparam int RR_PTR_W = (RR_N > 1) ? $clog2(RR_N) : 1;
    localparam logic [NUM_REQ-1:0] LSB_ONE = NUM_REQ'(1);

    arb_state_t         state_reg, state_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic               we_reg, we_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [DATA_W-1:0]  wdata_reg, wdata_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [NUM_REQ-1:0] ack_reg, ack_next;
    logic [DATA_W-1:0]  rdata_reg, rdata_next;

    logic [ADDR_W-1:0]  req_addr  [NUM_REQ];
    logic [DATA_W-1:0]  req_wdata [NUM_REQ];
    logic [RR_N-1:0]    rr_gnt;
    logic               rr_found;
    logic [RR_PTR_W-1:0] rr_ptr;
    logic [NUM_REQ-1:0] starving;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;

    genvar gi;

    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_addr[gi]  = bus.i_addr[gi*ADDR_W +: ADDR_W];
        assign req_wdata[gi] = bus.i_wdata[gi*DATA_W +: DATA_W];
    end

    // The picker only sees requesters 1..NUM_REQ-1, so its index is one lower.
    assign rr_ptr = RR_PTR_W'(ptr_reg - IDX_W'(1));

    rr_picker #(.N(RR_N)) u_rr_picker (
        .req   (bus.i_req[NUM_REQ-1:1]),
        .ptr   (rr_ptr),
        .gnt   (rr_gnt),
        .found (rr_found)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    assign starving[0] = 1'b0;
    for (gi = 1; gi < NUM_REQ; gi++) begin : g_starve
        logic [CNT_W-1:0] cnt_reg;
        logic             is_owner;

        assign is_owner = (state_reg != ARB_IDLE) && (owner_reg == IDX_W'(gi));

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                cnt_reg <= '0;
            end else if (gnt_next[gi]) begin
                cnt_reg <= '0;
            end else if (bus.i_req[gi] && !is_owner && (cnt_reg != CNT_W'(STARVE_LIMIT))) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end

        // Only a requester still asking can win; a dropped request is never served.
        assign starving[gi] = bus.i_req[gi] && (cnt_reg >= CNT_W'(STARVE_LIMIT));
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign starving            = '0;
`endif

    // Winner: starving requester (lowest index) > record > round-robin.
    always_comb begin
        win_onehot = '0;
        if (|starving) begin
            win_onehot = starving & (~starving + LSB_ONE);
        end else if (bus.i_req[REQ_REC]) begin
            win_onehot[REQ_REC] = 1'b1;
        end else if (rr_found) begin
            win_onehot = {rr_gnt, 1'b0};
        end
    end

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_onehot[k]) begin
                win_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        ptr_next   = ptr_reg;
        gnt_next   = '0;
        ack_next   = '0;
        rdata_next = rdata_reg;
        case (state_reg)
            ARB_IDLE: begin
                // The ack cycle is spent idle without arbitrating.
                if (!(|ack_reg) && (|bus.i_req)) begin
                    state_next = ARB_ISSUE;
                    owner_next = win_idx;
                    we_next    = bus.i_we[win_idx];
                    addr_next  = req_addr[win_idx];
                    wdata_next = req_wdata[win_idx];
                    gnt_next   = win_onehot;
                    if (win_idx != IDX_W'(REQ_REC)) begin
                        ptr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1)
                                                                    : win_idx + IDX_W'(1);
                    end
                end
            end
            ARB_ISSUE: begin
                if (bus.i_mem_ready) begin
                    if (we_reg) begin
                        state_next          = ARB_IDLE;
                        ack_next[owner_reg] = 1'b1;
                    end else begin
                        state_next = ARB_WAIT_RD;
                    end
                end
            end
            ARB_WAIT_RD: begin
                if (bus.i_mem_rvalid) begin
                    state_next          = ARB_IDLE;
                    rdata_next          = bus.i_mem_rdata;
                    ack_next[owner_reg] = 1'b1;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ARB_IDLE;
            owner_reg <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            ptr_reg   <= IDX_W'(1);
            gnt_reg   <= '0;
            ack_reg   <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= gnt_next;
            ack_reg   <= ack_next;
            rdata_reg <= rdata_next;
        end
    end

    // Memory fields are forced to zero whenever no request is presented.
    assign bus.o_mem_req   = (state_reg == ARB_ISSUE);
    assign bus.o_mem_we    = bus.o_mem_req && we_reg;
    assign bus.o_mem_addr  = bus.o_mem_req ? addr_reg  : '0;
    assign bus.o_mem_wdata = bus.o_mem_req ? wdata_reg : '0;
    assign bus.o_gnt       = gnt_reg;
    assign bus.o_ack       = ack_reg;
    assign bus.o_rdata     = rdata_reg;
    assign bus.o_busy      = (state_reg != ARB_IDLE);

endmodule
